// File: rtl/reg_file_pkg.sv
// Shared types and constants for the synchronous register file.
package reg_file_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned DEF_NREAD = 2;

  // LSB of field `port` inside a packed bus of `width`-bit fields.
  function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: sweep blanking, hardwired zero and write bypass.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             active,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             byp_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  always_comb begin
    rd_data = '0;
    if (!active) begin
      rd_data = '0;
    end else if (ZERO_REG && (rd_addr == '0)) begin
      rd_data = '0;
    end else if (BYPASS && byp_en && (rd_addr == wr_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = mem_data;
    end
  end

endmodule

// File: rtl/reg_file_sync.sv
// Clocked register file with NREAD combinational read ports and a clear sweep
// that zeroes every entry after reset or on CLR before accepting writes.
module reg_file_sync
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NREAD    = DEF_NREAD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CLR,
  input  logic                   RegWEN,
  input  logic [AW-1:0]          WRITE_REG,
  input  logic [WIDTH-1:0]       REG_DATA_W,
  input  logic [NREAD*AW-1:0]    READ_REG,
  output logic [NREAD*WIDTH-1:0] READ_DATA,
  output logic                   READY
);

  state_e           state_reg, state_next;
  logic [AW-1:0]    idx_reg, idx_next;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             is_idle;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= SWEEP;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (CLR) begin
      state_next = SWEEP;
      idx_next   = '0;
    end else begin
      case (state_reg)
        SWEEP: begin
          idx_next = idx_reg + AW'(1);
          if (idx_reg == AW'(DEPTH - 1)) state_next = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Sweep owns the write port; CLR in the same cycle drops a core write.
  always_comb begin
    is_idle   = (state_reg == IDLE);
    READY     = is_idle;
    mem_we    = 1'b0;
    mem_waddr = WRITE_REG;
    mem_wdata = REG_DATA_W;
    if (!is_idle) begin
      mem_we    = 1'b1;
      mem_waddr = idx_reg;
      mem_wdata = '0;
    end else if (RegWEN && !CLR && !(ZERO_REG && (WRITE_REG == '0))) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0] rd_addr;
      assign rd_addr = READ_REG[slice_lsb(gi, AW) +: AW];

      reg_file_read_port #(
        .WIDTH   (WIDTH),
        .AW      (AW),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
      ) u_port (
        .active  (is_idle),
        .rd_addr (rd_addr),
        .mem_data(mem[rd_addr]),
        .byp_en  (RegWEN && !CLR),
        .wr_addr (WRITE_REG),
        .wr_data (REG_DATA_W),
        .rd_data (READ_DATA[slice_lsb(gi, WIDTH) +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: doc/reg_file_sync.md
# reg_file_sync

Parametrised, clock-synchronous register file for the single-cycle core, replacing the level-sensitive array. It provides one write port and NREAD combinational read ports, with optional hardwired-zero entry 0 and optional write-to-read bypass. A built-in clear sequencer sweeps every entry to zero after reset or on request. The core must hold off register writes until READY is high.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 32: number of entries; power of two, ≥2. AW = $clog2(DEPTH).
- NREAD, 2: number of read ports, ≥1.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: when 1, a read of the address being written this cycle returns REG_DATA_W.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- CLR  in  1  synchronous request to re-run the clear sweep.
- RegWEN  in  1  write enable.
- WRITE_REG  in  AW  write address.
- REG_DATA_W  in  WIDTH  write data.
- READ_REG  in  NREAD*AW  packed read addresses; port p occupies bits [p*AW +: AW].
- READ_DATA  out  NREAD*WIDTH  packed read data; port p occupies bits [p*WIDTH +: WIDTH].
- READY  out  1  high once the sweep is complete and writes are accepted.

## Operation
- Two-state FSM: SWEEP and IDLE. A sweep counter idx has width AW.
- RST low: asynchronously sets state=SWEEP, idx=0, READY=0. Array contents are not reset.
- SWEEP: each edge writes entry[idx] <= 0 and increments idx. On the edge where idx==DEPTH-1, the state moves to IDLE. RegWEN is ignored and READ_DATA is all zeros.
- IDLE: READY=1. An edge with RegWEN=1 writes entry[WRITE_REG] <= REG_DATA_W, except that address 0 is dropped when ZERO_REG=1.
- CLR=1 at an edge, in any state: state <= SWEEP, idx <= 0. A write presented in the same cycle is dropped. CLR during a sweep restarts it from entry 0.
- Read port p in IDLE, evaluated in priority order:
  - if ZERO_REG and address 0, return 0;
  - else if BYPASS and RegWEN and READ_REG[p]==WRITE_REG and CLR=0, return REG_DATA_W;
  - else return entry[READ_REG[p]].
- All read ports are independent; any number of ports may read the same address.
- Data is stored and returned unmodified. There is no sign handling.

## Timing
- Reset values: READY=0; READ_DATA=0 while in SWEEP.
- Sweep latency: READY rises after exactly DEPTH rising edges following RST deassertion, or following the edge that sampled CLR.
- Read latency: zero cycles (combinational from READ_REG, state, and the bypass inputs).
- Write latency: one edge. With BYPASS=0, a same-cycle read returns the old value and the new value is visible after the edge.
- RST asserted mid-sweep or mid-write: the write is lost and a full sweep follows.
- CLR held high keeps the block in SWEEP with idx=0 and READY=0.

## Structure
- Package reg_file_pkg holds:
  - the state enum (SWEEP, IDLE);
  - default parameter constants (WIDTH 32, DEPTH 32, NREAD 2);
  - a function for the packed slice offset.
- Sub-module reg_file_read_port implements the address mux, zero check and bypass for one port. It is instantiated NREAD times with a generate loop.
- The top level contains the array, the FSM, the sweep counter and the write logic.

## Test plan
- Reset, then count edges → READY=0 for 32 edges and 1 after the 32nd; all ports read 0 throughout.
- IDLE, write 0xDEADBEEF to x5, then read x5 on both ports next cycle → both return 0xDEADBEEF.
- Same cycle write 0x12345678 to x7 with READ_REG port0=7 → BYPASS=1 returns 0x12345678; BYPASS=0 returns the previous value.
- Write 0xFFFFFFFF to x0 (ZERO_REG=1), then read x0 → 0; with ZERO_REG=0 → 0xFFFFFFFF.
- Write x3=0xA5A5A5A5, pulse CLR with a simultaneous write to x4 → READY drops for 32 edges; afterwards x3=0 and x4=0.
- Assert RST at sweep edge 10, release → sweep restarts; READY rises 32 edges after release.
